// File: rtl/fetch_mem_sequencer_pkg.sv
// Shared types and default sizing for the fetch/memory sequencer.
package fetch_mem_pkg;

    localparam int          DEF_ADDR_W   = 32;
    localparam int          DEF_DATA_W   = 32;
    localparam int unsigned DEF_RESET_PC = 0;
    localparam int unsigned DEF_PC_STEP  = 1;
    localparam int          DEF_TIMEOUT  = 15;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_MEM   = 3'd3,
        ST_ERR   = 3'd4
    } seq_state_e;

endpackage

// File: rtl/fetch_mem_sequencer_if.sv
// Unified instruction/data memory port: sequencer is master, memory is slave.
interface fetch_mem_sequencer_if #(
    parameter int ADDR_W = fetch_mem_pkg::DEF_ADDR_W,
    parameter int DATA_W = fetch_mem_pkg::DEF_DATA_W
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/fetch_mem_sequencer_timer.sv
// Wait-state counter for one memory access; tc flags the last allowed cycle.
module mem_wait_timer
    import fetch_mem_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;

    // Count cycles spent requesting without an ack; restart on each new access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    // The cycle whose wait would make TIMEOUT unacknowledged cycles.
    assign tc_o = (cnt_q == CW'(TIMEOUT - 1));
endmodule

// File: rtl/fetch_mem_sequencer.sv
// Multicycle fetch / load-store sequencer owning PC, IR and MDR.
module fetch_mem_sequencer
    import fetch_mem_pkg::*;
#(
    parameter int          ADDR_W   = DEF_ADDR_W,
    parameter int          DATA_W   = DEF_DATA_W,
    parameter int unsigned RESET_PC = DEF_RESET_PC,
    parameter int unsigned PC_STEP  = DEF_PC_STEP,
    parameter int          TIMEOUT  = DEF_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic                  halt,
    input  logic                  branch_en,
    input  logic [ADDR_W-1:0]     branch_target,
    input  logic                  ls_req,
    input  logic                  ls_we,
    input  logic [ADDR_W-1:0]     ls_addr,
    input  logic [DATA_W-1:0]     ls_wdata,
    fetch_mem_sequencer_if.master mem,
    output logic [ADDR_W-1:0]     pc_out,
    output logic [DATA_W-1:0]     ir_out,
    output logic [DATA_W-1:0]     mdr_out,
    output logic                  ir_valid,
    output logic                  ls_done,
    output logic                  busy,
    output logic                  err
);
    seq_state_e        state_q, state_d;
    logic              req_q, req_d;
    logic              hs, tc, tmr_clr, tmr_en;
    logic [ADDR_W-1:0] pc_q, pc_d, ls_addr_q;
    logic [DATA_W-1:0] ir_q, mdr_q, ls_wdata_q;
    logic              ls_we_q, ir_valid_q, ls_done_q;

    // An ack only counts while we are actually requesting.
    assign hs = req_q & mem.mem_ack;

    // Request is held through the access and dropped for one cycle after
    // every ack, so back-to-back accesses always show a low cycle.
    assign req_d = ((state_d == ST_FETCH) || (state_d == ST_MEM)) && !hs;

    assign tmr_clr = (state_d != state_q) &&
                     ((state_d == ST_FETCH) || (state_d == ST_MEM));
    assign tmr_en  = req_q && !mem.mem_ack;

    mem_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clr_i (tmr_clr),
        .en_i  (tmr_en),
        .tc_o  (tc)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // Next-state: boundaries after EXEC/MEM honour halt and run; ERR only exits via reset.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (run && !halt) state_d = ST_FETCH;
            ST_FETCH: begin
                if (hs)              state_d = ST_EXEC;
                else if (req_q && tc) state_d = ST_ERR;
            end
            ST_EXEC: begin
                if (ls_req)            state_d = ST_MEM;
                else if (halt || !run) state_d = ST_IDLE;
                else                   state_d = ST_FETCH;
            end
            ST_MEM: begin
                if (hs)               state_d = (halt || !run) ? ST_IDLE : ST_FETCH;
                else if (req_q && tc) state_d = ST_ERR;
            end
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_IDLE;
        endcase
    end

    // Bus and status outputs decoded from state and registers only.
    always_comb begin
        mem.mem_req   = req_q;
        mem.mem_we    = 1'b0;
        mem.mem_addr  = '0;
        mem.mem_wdata = '0;
        if (req_q) begin
            if (state_q == ST_MEM) begin
                mem.mem_we    = ls_we_q;
                mem.mem_addr  = ls_addr_q;
                mem.mem_wdata = ls_wdata_q;
            end else begin
                mem.mem_addr  = pc_q;
            end
        end
        busy = (state_q == ST_FETCH) || (state_q == ST_EXEC) || (state_q == ST_MEM);
        err  = (state_q == ST_ERR);
    end

    // PC: step on fetch completion, a branch in EXEC overrides.
    always_comb begin
        pc_d = pc_q;
        if ((state_q == ST_FETCH) && hs)          pc_d = pc_q + ADDR_W'(PC_STEP);
        else if ((state_q == ST_EXEC) && branch_en) pc_d = branch_target;
    end

    // Datapath registers and one-cycle completion pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q       <= ADDR_W'(RESET_PC);
            req_q      <= 1'b0;
            ir_q       <= '0;
            mdr_q      <= '0;
            ls_we_q    <= 1'b0;
            ls_addr_q  <= '0;
            ls_wdata_q <= '0;
            ir_valid_q <= 1'b0;
            ls_done_q  <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            req_q      <= req_d;
            ir_valid_q <= (state_q == ST_FETCH) && hs;
            ls_done_q  <= (state_q == ST_MEM) && hs;
            if ((state_q == ST_FETCH) && hs) ir_q <= mem.mem_rdata;
            if ((state_q == ST_EXEC) && ls_req) begin
                ls_we_q    <= ls_we;
                ls_addr_q  <= ls_addr;
                ls_wdata_q <= ls_wdata;
            end
            if ((state_q == ST_MEM) && hs && !ls_we_q) mdr_q <= mem.mem_rdata;
        end
    end

    assign pc_out   = pc_q;
    assign ir_out   = ir_q;
    assign mdr_out  = mdr_q;
    assign ir_valid = ir_valid_q;
    assign ls_done  = ls_done_q;
endmodule

// File: tb/tb_fetch_mem_sequencer.sv
// Bench: memory responder plus transaction-level model of the sequencer.
module tb_fetch_mem_sequencer;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 15;

    localparam int M_IDLE  = 0;
    localparam int M_FETCH = 1;
    localparam int M_EXEC  = 2;
    localparam int M_DATA  = 3;
    localparam int M_ERR   = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          run, halt, branch_en, ls_req, ls_we;
    logic [AW-1:0] branch_target, ls_addr;
    logic [DW-1:0] ls_wdata;
    logic [AW-1:0] pc_out;
    logic [DW-1:0] ir_out, mdr_out;
    logic          ir_valid, ls_done, busy, err;

    fetch_mem_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) mif ();

    fetch_mem_sequencer #(
        .ADDR_W(AW), .DATA_W(DW), .RESET_PC(0), .PC_STEP(1), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .run(run), .halt(halt),
        .branch_en(branch_en), .branch_target(branch_target),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .mem(mif),
        .pc_out(pc_out), .ir_out(ir_out), .mdr_out(mdr_out),
        .ir_valid(ir_valid), .ls_done(ls_done), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // stimulus shadows, applied at the falling edge
    logic          s_rst, s_run, s_halt, s_br, s_lsreq, s_lswe;
    logic [AW-1:0] s_tgt, s_lsaddr;
    logic [DW-1:0] s_lswdata;
    int            force_lat;  // >=0 fixed latency, -1 random, -2 never ack
    int            lat;

    // memories: bm seen by the responder, mm kept by the model
    logic [DW-1:0] bm [64];
    logic [DW-1:0] mm [64];

    // model
    int            m_mode, m_wait;
    bit            m_gap, m_irv, m_lsd, m_lwe;
    logic [AW-1:0] m_pc, m_laddr;
    logic [DW-1:0] m_ir, m_mdr, m_lwdata;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic bit exp_req();
        return ((m_mode == M_FETCH) && !m_gap) || (m_mode == M_DATA);
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_wait = 0; m_gap = 0; m_irv = 0; m_lsd = 0;
        m_pc = '0; m_ir = '0; m_mdr = '0; m_lwe = 0; m_laddr = '0; m_lwdata = '0;
    endtask

    // Transaction-level step applied after each rising edge.
    task automatic model_step();
        bit ack;
        ack = mif.mem_ack;
        m_irv = 0;
        m_lsd = 0;
        if (!rst) begin
            model_reset();
            return;
        end
        case (m_mode)
            M_IDLE: if (run && !halt) begin m_mode = M_FETCH; m_gap = 0; m_wait = 0; end
            M_FETCH: begin
                if (m_gap) m_gap = 0;
                else if (ack) begin
                    m_ir = mm[m_pc[5:0]]; m_pc = m_pc + 1; m_irv = 1; m_mode = M_EXEC;
                end else begin
                    m_wait++;
                    if (m_wait >= TO) m_mode = M_ERR;
                end
            end
            M_EXEC: begin
                if (branch_en) m_pc = branch_target;
                if (ls_req) begin
                    m_lwe = ls_we; m_laddr = ls_addr; m_lwdata = ls_wdata;
                    m_mode = M_DATA; m_wait = 0;
                end else if (halt || !run) m_mode = M_IDLE;
                else begin m_mode = M_FETCH; m_gap = 0; m_wait = 0; end
            end
            M_DATA: begin
                if (ack) begin
                    if (m_lwe) mm[m_laddr[5:0]] = m_lwdata;
                    else       m_mdr = mm[m_laddr[5:0]];
                    m_lsd = 1;
                    if (halt || !run) m_mode = M_IDLE;
                    else begin m_mode = M_FETCH; m_gap = 1; m_wait = 0; end
                end else begin
                    m_wait++;
                    if (m_wait >= TO) m_mode = M_ERR;
                end
            end
            default: ;
        endcase
    endtask

    // Per-cycle comparison of every DUT output against the model.
    task automatic compare();
        bit er;
        er = exp_req();
        chk("pc_out", pc_out, m_pc);
        chk("ir_out", ir_out, m_ir);
        chk("mdr_out", mdr_out, m_mdr);
        chk("ir_valid", ir_valid, m_irv);
        chk("ls_done", ls_done, m_lsd);
        chk("busy", busy, (m_mode == M_FETCH) || (m_mode == M_EXEC) || (m_mode == M_DATA));
        chk("err", err, m_mode == M_ERR);
        chk("mem_req", mif.mem_req, er);
        if (er) begin
            chk("mem_addr", mif.mem_addr, (m_mode == M_DATA) ? m_laddr : m_pc);
            chk("mem_we", mif.mem_we, (m_mode == M_DATA) && m_lwe);
            if ((m_mode == M_DATA) && m_lwe) chk("mem_wdata", mif.mem_wdata, m_lwdata);
        end
    endtask

    // Memory responder: chooses ack and read data for the coming edge.
    task automatic respond();
        if (!rst || force_lat == -2) begin
            mif.mem_ack = 1'b0;
            lat = -1;
        end else if (mif.mem_req) begin
            if (lat < 0) lat = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 3));
            if (lat == 0) begin
                mif.mem_ack = 1'b1;
                lat = -1;
                if (mif.mem_we) bm[mif.mem_addr[5:0]] = mif.mem_wdata;
            end else begin
                mif.mem_ack = 1'b0;
                lat--;
            end
        end else begin
            mif.mem_ack = (force_lat == -1) && ($urandom_range(0, 3) == 0);
            lat = -1;
        end
        mif.mem_rdata = mif.mem_req ? bm[mif.mem_addr[5:0]] : DW'($urandom);
    endtask

    task automatic cycle();
        @(negedge clk);
        compare();
        rst = s_rst; run = s_run; halt = s_halt;
        branch_en = s_br; branch_target = s_tgt;
        ls_req = s_lsreq; ls_we = s_lswe; ls_addr = s_lsaddr; ls_wdata = s_lswdata;
        respond();
        @(posedge clk);
        #1;
        model_step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 0; run = 0; halt = 0; branch_en = 0; branch_target = '0;
        ls_req = 0; ls_we = 0; ls_addr = '0; ls_wdata = '0;
        mif.mem_ack = 0; mif.mem_rdata = '0;
        s_rst = 0; s_run = 0; s_halt = 0; s_br = 0; s_tgt = '0;
        s_lsreq = 0; s_lswe = 0; s_lsaddr = '0; s_lswdata = '0;
        force_lat = 0; lat = -1;
        for (int i = 0; i < 64; i++) begin bm[i] = DW'($urandom); mm[i] = bm[i]; end
        bm[0] = 69;     mm[0] = 69;
        bm[1] = 'h1234; mm[1] = 'h1234;
        model_reset();

        // reset held two cycles
        cycle(); cycle();
        chk("rst_pc", pc_out, 0); chk("rst_ir", ir_out, 0); chk("rst_mdr", mdr_out, 0);
        chk("rst_req", mif.mem_req, 0); chk("rst_busy", busy, 0); chk("rst_err", err, 0);

        // zero-wait fetch of word 69 at address 0
        s_rst = 1; s_run = 1; force_lat = 0;
        cycle(); chk("f0_req", mif.mem_req, 1); chk("f0_addr", mif.mem_addr, 0);
        cycle(); chk("f0_ir", ir_out, 69); chk("f0_irv", ir_valid, 1); chk("f0_pc", pc_out, 1);
        cycle(); chk("f1_addr", mif.mem_addr, 1); chk("f1_req", mif.mem_req, 1);

        // three wait states
        force_lat = 3;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("ws_req", mif.mem_req, 1); chk("ws_addr", mif.mem_addr, 1);
            chk("ws_err", err, 0); chk("ws_irv", ir_valid, 0);
        end
        cycle(); chk("ws_ir", ir_out, 'h1234); chk("ws_irv1", ir_valid, 1); chk("ws_pc", pc_out, 2);

        // store 69 to address 10, then load it back
        force_lat = 0;
        s_lsreq = 1; s_lswe = 1; s_lsaddr = 10; s_lswdata = 69;
        cycle(); chk("st_we", mif.mem_we, 1); chk("st_addr", mif.mem_addr, 10);
        chk("st_wdata", mif.mem_wdata, 69);
        s_lsreq = 0; s_lswe = 0; s_lsaddr = 0; s_lswdata = 0;
        cycle(); chk("st_done", ls_done, 1); chk("st_gap", mif.mem_req, 0);
        cycle(); chk("f2_addr", mif.mem_addr, 2);
        cycle();
        s_lsreq = 1; s_lswe = 0; s_lsaddr = 10;
        cycle(); chk("ld_we", mif.mem_we, 0); chk("ld_addr", mif.mem_addr, 10);
        s_lsreq = 0; s_lsaddr = 0;
        cycle(); chk("ld_done", ls_done, 1); chk("ld_mdr", mdr_out, 69);
        chk("model_mdr", m_mdr, 69);
        cycle(); cycle();

        // branch to 0x40, then halt during that fetch
        s_br = 1; s_tgt = 'h40;
        cycle(); chk("br_addr", mif.mem_addr, 'h40); chk("br_pc", pc_out, 'h40);
        s_br = 0; s_tgt = 0; s_halt = 1; force_lat = 1;
        cycle(); chk("hl_req", mif.mem_req, 1);
        cycle(); chk("hl_irv", ir_valid, 1); chk("hl_pc", pc_out, 'h41); chk("hl_ir", ir_out, 69);
        chk("model_pc", m_pc, 'h41);
        cycle(); chk("hl_busy", busy, 0); chk("hl_req0", mif.mem_req, 0);
        s_halt = 0;

        // randomized operation
        force_lat = -1;
        for (int i = 0; i < 3000; i++) begin
            s_run     = ($urandom_range(0, 9) != 0);
            s_halt    = ($urandom_range(0, 9) == 0);
            s_br      = ($urandom_range(0, 3) == 0);
            s_tgt     = AW'($urandom_range(0, 63));
            s_lsreq   = ($urandom_range(0, 4) < 2);
            s_lswe    = ($urandom_range(0, 1) == 1);
            s_lsaddr  = AW'($urandom_range(0, 63));
            s_lswdata = DW'($urandom);
            cycle();
        end

        // reset asserted mid-fetch drops mem_req without a clock edge
        s_run = 1; s_halt = 0; s_br = 0; s_lsreq = 0; force_lat = -2;
        s_rst = 0; cycle(); cycle();
        s_rst = 1; cycle();
        cycle(); chk("pre_rst_req", mif.mem_req, 1);
        @(negedge clk);
        #2; rst = 0; s_rst = 0;
        #1; chk("async_req", mif.mem_req, 0); chk("async_busy", busy, 0); chk("async_pc", pc_out, 0);
        model_reset();
        cycle();

        // timeout: no ack for exactly TO request cycles
        s_rst = 1; cycle();
        for (int i = 0; i < TO - 1; i++) begin
            cycle(); chk("to_wait_req", mif.mem_req, 1); chk("to_wait_err", err, 0);
        end
        cycle(); chk("to_err", err, 1); chk("to_req", mif.mem_req, 0);
        force_lat = -1;
        for (int i = 0; i < 4; i++) begin
            cycle(); chk("err_sticky", err, 1); chk("err_busy", busy, 0); chk("err_req", mif.mem_req, 0);
        end
        s_rst = 0; cycle(); chk("err_clear", err, 0); chk("err_clear_pc", pc_out, 0);
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
